// File: rtl/addr_pipe_chain.sv
// addr_pipe_chain: chain of register-address pipeline stages (ID/EX .. MEM/WB).
// Every stage holds {valid, rd, wen}. Stage 0 also holds rs1/rs2 for the EX
// operand muxes. All stages update on the falling edge of clk.
//
// Optional feature macro: ADDR_PIPE_FWD_EN
//   defined   -> fwd_rs1_sel/fwd_rs2_sel name the youngest stage k in 1..STAGES-1
//                whose valid write targets stage-0 rs1/rs2 (0 = no forwarding)
//   undefined -> both selects tie to 0 and no comparators are built
//
// Flow control (no ready path; the decode side owns back-pressure):
//   in_valid marks a real instruction in the decode slot. stall holds stage 0
//   and drops a bubble into stage 1. flush turns the stage 0 capture into a
//   bubble and wins over stall. Stages 2 and later always advance.
module addr_pipe_chain #(
  parameter int ADDR_W = 5,
  parameter int STAGES = 3,
  localparam int SEL_W = $clog2(STAGES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [ADDR_W-1:0]        rs1_in,
  input  logic [ADDR_W-1:0]        rs2_in,
  input  logic [ADDR_W-1:0]        rd_in,
  input  logic                     wen_in,
  input  logic                     stall,
  input  logic                     flush,
  output logic [ADDR_W-1:0]        rs1_out,
  output logic [ADDR_W-1:0]        rs2_out,
  output logic [ADDR_W-1:0]        rd_out,
  output logic                     wen_out,
  output logic                     valid_out,
  output logic [ADDR_W-1:0]        wb_rd,
  output logic                     wb_wen,
  output logic [STAGES*ADDR_W-1:0] stage_rd,
  output logic [STAGES-1:0]        stage_wen,
  output logic [SEL_W-1:0]         fwd_rs1_sel,
  output logic [SEL_W-1:0]         fwd_rs2_sel
);

  // Stage 0 source registers (only the ID/EX stage feeds operand muxes)
  logic [ADDR_W-1:0] rs1_q, rs1_d;
  logic [ADDR_W-1:0] rs2_q, rs2_d;

  // Per-stage destination fields
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] wen_q,   wen_d;
  logic [ADDR_W-1:0] rd_q [STAGES];
  logic [ADDR_W-1:0] rd_d [STAGES];

  // Next-state: stage 0 capture/hold/bubble, stage 1 bubble on stall, rest shift
  always_comb begin
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    valid_d = valid_q;
    wen_d   = wen_q;
    for (int k = 0; k < STAGES; k++) rd_d[k] = rd_q[k];

    if (flush) begin
      valid_d[0] = 1'b0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d[0]    = '0;
      wen_d[0]   = 1'b0;
    end else if (!stall) begin
      valid_d[0] = in_valid;
      rs1_d      = rs1_in;
      rs2_d      = rs2_in;
      rd_d[0]    = rd_in;
      wen_d[0]   = wen_in & in_valid;
    end

    if (stall) begin
      valid_d[1] = 1'b0;
      rd_d[1]    = '0;
      wen_d[1]   = 1'b0;
    end else begin
      valid_d[1] = valid_q[0];
      rd_d[1]    = rd_q[0];
      wen_d[1]   = wen_q[0];
    end

    for (int k = 2; k < STAGES; k++) begin
      valid_d[k] = valid_q[k-1];
      rd_d[k]    = rd_q[k-1];
      wen_d[k]   = wen_q[k-1];
    end
  end

  // Stage registers: falling-edge update, asynchronous clear to all-bubble
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_q   <= '0;
      rs2_q   <= '0;
      valid_q <= '0;
      wen_q   <= '0;
      for (int k = 0; k < STAGES; k++) rd_q[k] <= '0;
    end else begin
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      valid_q <= valid_d;
      wen_q   <= wen_d;
      for (int k = 0; k < STAGES; k++) rd_q[k] <= rd_d[k];
    end
  end

  // Flatten per-stage rd/wen; the valid AND keeps a bubble from ever reporting a write
  always_comb begin
    stage_rd  = '0;
    stage_wen = '0;
    for (int k = 0; k < STAGES; k++) begin
      stage_rd[k*ADDR_W +: ADDR_W] = rd_q[k];
      stage_wen[k]                 = wen_q[k] & valid_q[k];
    end
  end

  assign rs1_out   = rs1_q;
  assign rs2_out   = rs2_q;
  assign rd_out    = rd_q[0];
  assign wen_out   = stage_wen[0];
  assign valid_out = valid_q[0];
  assign wb_rd     = rd_q[STAGES-1];
  assign wb_wen    = stage_wen[STAGES-1];

`ifdef ADDR_PIPE_FWD_EN
  // Forwarding select: scan oldest to youngest so the youngest matching stage wins
  always_comb begin
    fwd_rs1_sel = '0;
    fwd_rs2_sel = '0;
    for (int k = STAGES-1; k >= 1; k--) begin
      if (valid_q[0] && valid_q[k] && wen_q[k] && (rd_q[k] != '0)) begin
        if (rd_q[k] == rs1_q) fwd_rs1_sel = SEL_W'(k);
        if (rd_q[k] == rs2_q) fwd_rs2_sel = SEL_W'(k);
      end
    end
  end
`else
  assign fwd_rs1_sel = '0;
  assign fwd_rs2_sel = '0;
`endif

endmodule

// File: tb/tb_addr_pipe_chain.sv
// tb_addr_pipe_chain: directed bench for addr_pipe_chain at ADDR_W=5, STAGES=3.
// Inputs change just after each falling edge; outputs are sampled 1ns after it.
module tb_addr_pipe_chain;

  localparam int ADDR_W = 5;
  localparam int STAGES = 3;
  localparam int SEL_W  = $clog2(STAGES);
`ifdef ADDR_PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                     clk;
  logic                     rst_n;
  logic                     in_valid;
  logic [ADDR_W-1:0]        rs1_in, rs2_in, rd_in;
  logic                     wen_in, stall, flush;
  logic [ADDR_W-1:0]        rs1_out, rs2_out, rd_out;
  logic                     wen_out, valid_out;
  logic [ADDR_W-1:0]        wb_rd;
  logic                     wb_wen;
  logic [STAGES*ADDR_W-1:0] stage_rd;
  logic [STAGES-1:0]        stage_wen;
  logic [SEL_W-1:0]         fwd_rs1_sel, fwd_rs2_sel;

  int pass_cnt  = 0;
  int check_cnt = 0;

  addr_pipe_chain #(.ADDR_W(ADDR_W), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in), .wen_in(wen_in),
    .stall(stall), .flush(flush),
    .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out),
    .wen_out(wen_out), .valid_out(valid_out),
    .wb_rd(wb_rd), .wb_wen(wb_wen),
    .stage_rd(stage_rd), .stage_wen(stage_wen),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Driver: put one decode slot plus controls on the inputs
  task automatic drive(input logic v, input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2,
                       input logic [ADDR_W-1:0] rd, input logic w, input logic st, input logic fl);
    in_valid = v; rs1_in = r1; rs2_in = r2; rd_in = rd; wen_in = w; stall = st; flush = fl;
  endtask

  // Advance one falling edge and settle
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic bubble_tick();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    #12;
    chk("reset_stage_rd", stage_rd, 0);
    chk("reset_stage_wen", stage_wen, 0);
    chk("reset_valid", valid_out, 0);
    #5 rst_n = 1'b1;           // release at t=17, away from the falling edge
    tick();                    // now t=21

    // Flow: rd=5 enters at edge 0, reaches MEM/WB after edge 2
    drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    chk("flow_rd_out", rd_out, 5);
    chk("flow_wen_out", wen_out, 1);
    chk("flow_valid_out", valid_out, 1);
    chk("flow_rs_out", {rs1_out, rs2_out}, {5'd1, 5'd2});
    bubble_tick();
    chk("flow_stage1_rd", stage_rd[ADDR_W +: ADDR_W], 5);
    chk("flow_wb_early", wb_wen, 0);
    bubble_tick();
    chk("flow_wb_rd", wb_rd, 5);
    chk("flow_wb_wen", wb_wen, 1);

    // in_valid=0 with wen_in=1: write enable never appears in any stage
    drive(1'b0, 5'd4, 5'd4, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    chk("inv_wen_out", wen_out, 0);
    chk("inv_valid_out", valid_out, 0);
    chk("inv_rd_out", rd_out, 9);
    bubble_tick();
    chk("inv_stage_wen1", stage_wen, 0);
    bubble_tick();
    chk("inv_wb_rd", wb_rd, 9);
    chk("inv_wb_wen", wb_wen, 0);

    // Stall one cycle: stage 0 holds rs1=7, stage 1 bubbles, stage 2 advances
    drive(1'b1, 5'd1, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd7, 5'd6, 5'd11, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd9, 5'd8, 5'd12, 1'b1, 1'b1, 1'b0);
    tick();
    chk("stall_rs1_hold", rs1_out, 7);
    chk("stall_rd_hold", rd_out, 11);
    chk("stall_s1_rd", stage_rd[ADDR_W +: ADDR_W], 0);
    chk("stall_wen", stage_wen, 3'b101);
    chk("stall_wb_rd", wb_rd, 10);
    drive(1'b1, 5'd9, 5'd8, 5'd12, 1'b1, 1'b0, 1'b0);
    tick();
    chk("unstall_rd", stage_rd, {5'd0, 5'd11, 5'd12});
    chk("unstall_wen", stage_wen, 3'b011);

    // Flush + stall on the same edge: stage 0 and stage 1 both bubble
    drive(1'b1, 5'd3, 5'd3, 5'd13, 1'b1, 1'b1, 1'b1);
    tick();
    chk("fl_valid_out", valid_out, 0);
    chk("fl_wen_out", wen_out, 0);
    chk("fl_stage_rd", stage_rd, {5'd11, 5'd0, 5'd0});
    chk("fl_stage_wen", stage_wen, 3'b100);

    // Forwarding: both older stages write x3, youngest (stage 1) wins
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("fwd_youngest_rs1", fwd_rs1_sel, FWD ? 1 : 0);
    chk("fwd_nomatch_rs2", fwd_rs2_sel, 0);

    // Stage 1 wen=0 -> stage 2 supplies the operand; rs2 hits stage 2 too
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("fwd_older_rs1", fwd_rs1_sel, FWD ? 2 : 0);
    chk("fwd_older_rs2", fwd_rs2_sel, FWD ? 2 : 0);

    // rd=0 with wen=1 is carried as-is but never forwarded
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("x0_stage_wen", stage_wen, 3'b110);
    chk("fwd_x0_rs1", fwd_rs1_sel, 0);
    chk("fwd_x0_rs2", fwd_rs2_sel, 0);

    // Stage 0 invalid: no forwarding even when an older stage matches
    drive(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("fwd_s0_invalid", {fwd_rs1_sel, fwd_rs2_sel}, 0);

    // Reset mid-stream: load live state, then pull rst_n between edges
    drive(1'b1, 5'd21, 5'd22, 5'd23, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    chk("pre_rst_stage_wen", stage_wen, 3'b011);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_rd", stage_rd, 0);
    chk("rst_async_wen", stage_wen, 0);
    chk("rst_async_rs", {rs1_out, rs2_out, valid_out}, 0);
    tick();
    tick();
    chk("rst_hold_rd", stage_rd, 0);
    chk("rst_hold_valid", {valid_out, wb_wen, fwd_rs1_sel, fwd_rs2_sel}, 0);
    #3 rst_n = 1'b1;
    tick();
    chk("post_rst_rd_out", rd_out, 23);
    chk("post_rst_wb_rd", wb_rd, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
